// File: rtl/corr_scan_pkg.sv
// Shared constants and FSM encoding for the template-correlation scan sequencer.
// The frame-save logic uses the same FRAME_H_RES/FRAME_V_RES constants.
package corr_scan_pkg;

    localparam int unsigned FRAME_H_RES = 640;
    localparam int unsigned FRAME_V_RES = 480;

    localparam int unsigned COORD_W_DEF = 13;
    localparam int unsigned CORR_W_DEF  = 32;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LATCH   = 3'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT    = 3'd3;
    localparam logic [STATE_W-1:0] ST_UPDATE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_ADVANCE = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        StIdle    = ST_IDLE,
        StLatch   = ST_LATCH,
        StIssue   = ST_ISSUE,
        StWait    = ST_WAIT,
        StUpdate  = ST_UPDATE,
        StAdvance = ST_ADVANCE,
        StDone    = ST_DONE
    } scan_state_e;

endpackage

// File: rtl/corr_heartbeat.sv
// Enable-gated heartbeat divider: the LED toggles after every HB_DIV enabled cycles
// and holds its level while the enable is low.
module corr_heartbeat #(
    parameter int unsigned HB_DIV = 4194304
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_led
);

    localparam int unsigned CNT_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HB_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_led;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_led <= ~r_led;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/corr_scan_sequencer.sv
// Raster-scans a clipped search window through the correlation engine and reports the best match.
// Optional WAIT watchdog enabled by defining CORR_SCAN_TIMEOUT_EN.
module corr_scan_sequencer
    import corr_scan_pkg::*;
#(
    parameter int unsigned H_RES      = FRAME_H_RES,
    parameter int unsigned V_RES      = FRAME_V_RES,
    parameter int unsigned COORD_W    = COORD_W_DEF,
    parameter int unsigned CORR_W     = CORR_W_DEF,
    parameter int unsigned STEP       = 1,
    parameter int unsigned TMO_CYCLES = 4095,
    parameter int unsigned HB_DIV     = 4194304
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iFrameDone,
    input  logic [COORD_W-1:0] iWinX0,
    input  logic [COORD_W-1:0] iWinY0,
    input  logic [COORD_W-1:0] iWinW,
    input  logic [COORD_W-1:0] iWinH,
    output logic               oCorrStart,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    input  logic               iCorrFinished,
    input  logic [CORR_W-1:0]  iCurrentCorr,
    output logic [COORD_W-1:0] oXresult,
    output logic [COORD_W-1:0] oYresult,
    output logic [CORR_W-1:0]  oBestCorr,
    output logic               oResultValid,
    output logic               oBusy,
    output logic               oTimeout,
    output logic               oStatusLed
);

    // One extra bit so window-end sums and stride increments never wrap.
    localparam int unsigned EXT_W = COORD_W + 1;
    localparam logic [EXT_W-1:0] X_MAX    = EXT_W'(H_RES - 1);
    localparam logic [EXT_W-1:0] Y_MAX    = EXT_W'(V_RES - 1);
    localparam logic [EXT_W-1:0] STEP_EXT = EXT_W'(STEP);

    scan_state_e r_state;
    scan_state_e w_state_next;

    logic               r_fd_prev;
    logic               r_pend;
    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [EXT_W-1:0]   r_xend;
    logic [EXT_W-1:0]   r_yend;
    logic [CORR_W-1:0]  r_corr;
    logic [CORR_W-1:0]  r_best;
    logic [COORD_W-1:0] r_xres;
    logic [COORD_W-1:0] r_yres;
    logic               r_best_vld;

    logic               w_fd_rise;
    logic               w_busy;
    logic               w_degen;
    logic               w_tmo_hit;
    logic [EXT_W-1:0]   w_xsum;
    logic [EXT_W-1:0]   w_ysum;
    logic [EXT_W-1:0]   w_xend;
    logic [EXT_W-1:0]   w_yend;
    logic [EXT_W-1:0]   w_x_inc;
    logic [EXT_W-1:0]   w_y_inc;
    logic               w_x_wrap;
    logic               w_y_over;

    assign w_fd_rise = iFrameDone & ~r_fd_prev;
    assign w_busy    = (r_state != StIdle);

    assign w_xsum  = {1'b0, iWinX0} + {1'b0, iWinW} - EXT_W'(1);
    assign w_ysum  = {1'b0, iWinY0} + {1'b0, iWinH} - EXT_W'(1);
    assign w_xend  = (w_xsum > X_MAX) ? X_MAX : w_xsum;
    assign w_yend  = (w_ysum > Y_MAX) ? Y_MAX : w_ysum;
    assign w_degen = (iWinW == '0) || (iWinH == '0) ||
                     ({1'b0, iWinX0} > X_MAX) || ({1'b0, iWinY0} > Y_MAX);

    assign w_x_inc  = {1'b0, r_x} + STEP_EXT;
    assign w_y_inc  = {1'b0, r_y} + STEP_EXT;
    assign w_x_wrap = (w_x_inc > r_xend);
    assign w_y_over = (w_y_inc > r_yend);

`ifdef CORR_SCAN_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    assign w_tmo_hit = (r_state == StWait) && !iCorrFinished && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == StWait) && !iCorrFinished && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (r_state == StLatch) begin
                r_timeout <= 1'b0;
            end else if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign oTimeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign oTimeout  = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_fd_rise || r_pend) w_state_next = StLatch;
            StLatch:   w_state_next = w_degen ? StDone : StIssue;
            StIssue:   w_state_next = StWait;
            StWait: begin
                if (iCorrFinished) begin
                    w_state_next = StUpdate;
                end else if (w_tmo_hit) begin
                    w_state_next = StAdvance;
                end
            end
            StUpdate:  w_state_next = StAdvance;
            StAdvance: w_state_next = (w_x_wrap && w_y_over) ? StDone : StIssue;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state    <= StIdle;
            r_fd_prev  <= 1'b0;
            r_pend     <= 1'b0;
            r_x0       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_xend     <= '0;
            r_yend     <= '0;
            r_corr     <= '0;
            r_best     <= '0;
            r_xres     <= '0;
            r_yres     <= '0;
            r_best_vld <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_fd_prev <= iFrameDone;

            // A request arriving while busy is remembered once and consumed on leaving IDLE.
            if (r_state == StIdle) begin
                r_pend <= 1'b0;
            end else if (w_fd_rise) begin
                r_pend <= 1'b1;
            end

            unique case (r_state)
                StLatch: begin
                    r_x0       <= iWinX0;
                    r_x        <= iWinX0;
                    r_y        <= iWinY0;
                    r_xend     <= w_xend;
                    r_yend     <= w_yend;
                    r_best     <= '0;
                    r_xres     <= iWinX0;
                    r_yres     <= iWinY0;
                    r_best_vld <= 1'b0;
                end
                StWait: begin
                    if (iCorrFinished) begin
                        r_corr <= iCurrentCorr;
                    end
                end
                StUpdate: begin
                    // Strict compare so ties keep the earliest raster candidate.
                    if (!r_best_vld || (r_corr > r_best)) begin
                        r_best     <= r_corr;
                        r_xres     <= r_x;
                        r_yres     <= r_y;
                        r_best_vld <= 1'b1;
                    end
                end
                StAdvance: begin
                    if (!w_x_wrap) begin
                        r_x <= w_x_inc[COORD_W-1:0];
                    end else if (!w_y_over) begin
                        r_x <= r_x0;
                        r_y <= w_y_inc[COORD_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign oCorrStart   = (r_state == StIssue);
    assign oResultValid = (r_state == StDone);
    assign oBusy        = w_busy;
    assign oX           = r_x;
    assign oY           = r_y;
    assign oXresult     = r_xres;
    assign oYresult     = r_yres;
    assign oBestCorr    = r_best;

    corr_heartbeat #(
        .HB_DIV (HB_DIV)
    ) u_heartbeat (
        .i_clk   (iCLK),
        .i_rst_n (iRST_N),
        .i_en    (w_busy),
        .o_led   (oStatusLed)
    );

endmodule
